la_capture_engine: RTL

Parametrised multi-channel capture core for the FPGA logic analyzer. It replaces the fixed 4-channel, switch-driven sampling path. It samples `CH` asynchronous inputs at a programmable rate into a `DEPTH`-entry circular buffer, with a configurable pre-trigger window, four trigger modes and a freeze control. The OLED renderer reads the finished capture through a logical (oldest-first) read port.

---
 rtl/la_capture_engine.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/la_capture_engine.sv
// la_capture_engine: multi-channel logic analyzer capture core.
// Divided sampling into a circular buffer with pre-trigger window and freeze.
module la_capture_engine #(
  parameter int CH    = 8,
  parameter int DEPTH = 128,
  parameter int DIV_W = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    logic_in,
  input  logic [DIV_W-1:0] rate_div,
  input  logic [1:0]       trig_mode,
  input  logic [CH-1:0]    trig_mask,
  input  logic [CH-1:0]    trig_value,
  input  logic [AW-1:0]    pretrig,
  input  logic             arm,
  input  logic             freeze,
  input  logic [AW-1:0]    rd_addr,
  output logic [CH-1:0]    rd_data,
  output logic             busy,
  output logic             triggered,
  output logic             done
);

  localparam logic [AW-1:0]    A_ONE  = AW'(1);
  localparam logic [AW-1:0]    A_LAST = AW'(DEPTH - 1);
  localparam logic [DIV_W-1:0] D_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CH-1:0]    sync_q, smp_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    fill_q, fill_d;
  logic [AW-1:0]    pt_q, pt_d;
  logic [AW-1:0]    post_q, post_d;
  logic [AW-1:0]    trig_ptr_q, trig_ptr_d;
  logic [CH-1:0]    prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic             trig_q, trig_d;
  logic [CH-1:0]    rd_q;

  logic [CH-1:0] mem [DEPTH];

  logic          arm_ok;
  logic          tick;
  logic          active;
  logic          we;
  logic          hit;
  logic [AW-1:0] post_nx;
  logic [AW-1:0] rd_ptr;
  logic [CH-1:0] rise_v, fall_v;

  assign arm_ok  = arm & ~freeze;
  assign tick    = ~freeze & (cnt_q >= rate_div);
  assign active  = (state_q == S_PRE) |
                   (state_q == S_WAIT) |
                   (state_q == S_POST);
  // An accepted arm takes priority over a coincident write.
  assign we      = tick & active & ~arm_ok;
  assign post_nx = A_LAST - pt_q;
  assign rise_v  = ~prev_q & smp_q & trig_mask;
  assign fall_v  = prev_q & ~smp_q & trig_mask;

  always_comb begin
    hit = 1'b0;
    case (trig_mode)
      2'b00:   hit = 1'b1;
      2'b01:   hit = (smp_q & trig_mask) ==
                     (trig_value & trig_mask);
      2'b10:   hit = prev_valid_q & (|rise_v);
      2'b11:   hit = prev_valid_q & (|fall_v);
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (arm_ok) begin
      cnt_d = '0;
    end else if (!freeze) begin
      cnt_d = tick ? '0 : cnt_q + D_ONE;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    pt_d         = pt_q;
    post_d       = post_q;
    trig_ptr_d   = trig_ptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    trig_d       = trig_q;
    if (arm_ok) begin
      pt_d         = pretrig;
      wr_ptr_d     = '0;
      fill_d       = '0;
      trig_d       = 1'b0;
      prev_valid_d = 1'b0;
      state_d      = (pretrig == '0) ? S_WAIT : S_PRE;
    end else if (we) begin
      wr_ptr_d     = wr_ptr_q + A_ONE;
      prev_d       = smp_q;
      prev_valid_d = 1'b1;
      case (state_q)
        S_PRE: begin
          fill_d = fill_q + A_ONE;
          if (fill_d == pt_q) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (hit) begin
            trig_ptr_d = wr_ptr_q;
            trig_d     = 1'b1;
            post_d     = post_nx;
            state_d    = (post_nx == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          post_d = post_q - A_ONE;
          if (post_q == A_ONE) state_d = S_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      smp_q        <= '0;
      cnt_q        <= '0;
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      pt_q         <= '0;
      post_q       <= '0;
      trig_ptr_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_q       <= 1'b0;
    end else begin
      sync_q       <= logic_in;
      smp_q        <= sync_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      pt_q         <= pt_d;
      post_q       <= post_d;
      trig_ptr_q   <= trig_ptr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      trig_q       <= trig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= smp_q;
  end

  // Logical index 0 is the oldest sample, pt entries before the trigger.
  assign rd_ptr = trig_ptr_q - pt_q + rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_ptr];
    end
  end

  assign rd_data   = rd_q;
  assign busy      = active;
  assign triggered = trig_q;
  assign done      = (state_q == S_DONE);

endmodule
